rand_req_sched: RTL

//  Owns the 12-bit pseudo-random generator and shares it among NREQ game clients
//  (enemy spawner, bullet jitter, power-up drop, ...).
//  - Seeds the generator on each game start, using a free-running entropy counter
//    as the seed.
//  - Hands out one random sample per grant through a round-robin req/gnt handshake.
//  - Enforces a minimum gap between grants, so the generator advances and

---
 rtl/rand_req_sched.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rand_req_sched.sv
// Shares one 12-bit pseudo-random generator among NREQ clients: seeds it from a
// free-running entropy counter on game start, then grants samples round-robin.
module rand_req_sched #(
  parameter int NREQ     = 4,
  parameter int GAP      = 2,
  parameter int SEED_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            game_start,
  input  logic [11:0]     rand_in,
  input  logic [NREQ-1:0] req,
  output logic            lfsr_rst,
  output logic [11:0]     lfsr_seed,
  output logic [NREQ-1:0] gnt,
  output logic [11:0]     rand_out,
  output logic            rand_valid,
  output logic            seeded
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int SW = (SEED_CYC > 1) ? $clog2(SEED_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

  state_t          state;
  logic [11:0]     ent_cnt;
  logic [SW-1:0]   seed_cnt;
  logic [PW-1:0]   rr_ptr;
  logic [GW-1:0]   gap_cnt;
  logic [11:0]     seed_next;
  logic [PW:0]     cand_sum [NREQ];
  logic [PW-1:0]   cand [NREQ];
  logic [NREQ-1:0] hit;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   ptr_next;

  // The generator locks up on an all-zero seed, so substitute 1.
  assign seed_next = (ent_cnt == 12'd0) ? 12'h001 : ent_cnt;

  // hit[k] says whether the client k places after rr_ptr is requesting.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign cand_sum[gi] = {1'b0, rr_ptr} + (PW+1)'(gi);
    assign cand[gi]     = (cand_sum[gi] >= (PW+1)'(NREQ))
                          ? PW'(cand_sum[gi] - (PW+1)'(NREQ))
                          : cand_sum[gi][PW-1:0];
    assign hit[gi]      = req[cand[gi]];
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand[k];
      end
    end
  end

  assign ptr_next = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ent_cnt    <= '0;
      seed_cnt   <= '0;
      rr_ptr     <= '0;
      gap_cnt    <= '0;
      lfsr_rst   <= 1'b1;
      lfsr_seed  <= 12'h001;
      gnt        <= '0;
      rand_out   <= '0;
      rand_valid <= 1'b0;
      seeded     <= 1'b0;
    end else begin
      ent_cnt    <= ent_cnt + 12'd1;
      gnt        <= '0;
      rand_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (game_start) begin
            state     <= SEED;
            lfsr_seed <= seed_next;
            seed_cnt  <= SW'(SEED_CYC - 1);
          end
        end
        SEED: begin
          if (game_start) begin
            lfsr_seed <= seed_next;
            seed_cnt  <= SW'(SEED_CYC - 1);
          end else if (seed_cnt == '0) begin
            state    <= RUN;
            lfsr_rst <= 1'b0;
            seeded   <= 1'b1;
          end else begin
            seed_cnt <= seed_cnt - SW'(1);
          end
        end
        RUN: begin
          // A restart beats any grant decided in the same cycle.
          if (game_start) begin
            state     <= SEED;
            lfsr_seed <= seed_next;
            seed_cnt  <= SW'(SEED_CYC - 1);
            lfsr_rst  <= 1'b1;
            seeded    <= 1'b0;
            gap_cnt   <= '0;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (pick_found) begin
            gnt        <= NREQ'(1) << pick_idx;
            rand_out   <= rand_in;
            rand_valid <= 1'b1;
            rr_ptr     <= ptr_next;
            gap_cnt    <= GW'(GAP);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
